// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command sender; inhibits the bus, shifts the
// byte out LSB first with odd parity, checks the device ACK and guards the frame with a timeout.
module ps2_host_tx #(
   parameter int CLK_INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES     = 750000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       tx_done,
   output logic       tx_error,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);
   localparam int IW = $clog2(CLK_INHIBIT_CYCLES + 1);
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 20) ? $clog2(TIMEOUT_CYCLES + 1) : 20;
   localparam logic [IW-1:0] INH_LAST = IW'(CLK_INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] INHIBIT   = 3'd1;
   localparam logic [2:0] START     = 3'd2;
   localparam logic [2:0] DATA      = 3'd3;
   localparam logic [2:0] PARITY    = 3'd4;
   localparam logic [2:0] STOP      = 3'd5;
   localparam logic [2:0] ACK       = 3'd6;
   localparam logic [2:0] WAIT_IDLE = 3'd7;
   logic [2:0]    state_q, state_d;
   logic [IW-1:0] inh_q, inh_d;
   logic [TW-1:0] to_q, to_d;
   logic [8:0]    sh_q, sh_d;
   logic [2:0]    bit_q, bit_d;
   logic          clk_low_q, clk_low_d;
   logic          dat_low_q, dat_low_d;
   logic          err_q, err_d;
   logic [1:0]    clk_sync_q, dat_sync_q;
   logic          clk_prev_q;
   logic          clk_s, dat_s, fe, timed;
   assign clk_s     = clk_sync_q[1];
   assign dat_s     = dat_sync_q[1];
   assign fe        = clk_prev_q & ~clk_s;
   assign timed     = (state_q >= START) && (state_q <= ACK);
   assign cmd_ready = state_q == IDLE;
   assign tx_done   = state_q == WAIT_IDLE;
   assign tx_error  = err_q;
   assign PS2_CLK   = clk_low_q ? 1'b0 : 1'bz;
   assign PS2_DAT   = dat_low_q ? 1'b0 : 1'bz;
   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      to_d      = timed ? to_q + 1'b1 : to_q;
      sh_d      = sh_q;
      bit_d     = bit_q;
      clk_low_d = clk_low_q;
      dat_low_d = dat_low_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d   = INHIBIT;
            inh_d     = '0;
            sh_d      = {~^cmd_data, cmd_data};
            clk_low_d = 1'b1;
            dat_low_d = 1'b0;
         end
         INHIBIT: begin
            inh_d = inh_q + 1'b1;
            if (inh_q == INH_LAST) begin
               state_d   = START;
               clk_low_d = 1'b0;
               dat_low_d = 1'b1;
               to_d      = '0;
            end
         end
         START: if (fe) begin
            state_d   = DATA;
            dat_low_d = ~sh_q[0];
            sh_d      = sh_q >> 1;
            bit_d     = '0;
         end
         // bits 1..7 then parity leave through sh_q[0]; parity goes out on the 8th DATA edge
         DATA: if (fe) begin
            state_d   = (bit_q == 3'd7) ? PARITY : DATA;
            dat_low_d = ~sh_q[0];
            sh_d      = sh_q >> 1;
            bit_d     = bit_q + 1'b1;
         end
         PARITY: if (fe) begin
            state_d   = STOP;
            dat_low_d = 1'b0;
         end
         STOP: if (fe) begin
            state_d = dat_s ? IDLE : ACK;
            err_d   = dat_s;
         end
         ACK:       state_d = (clk_s && dat_s) ? WAIT_IDLE : ACK;
         default:   state_d = IDLE;
      endcase
      if (timed && to_q == TO_LAST) begin
         state_d   = IDLE;
         clk_low_d = 1'b0;
         dat_low_d = 1'b0;
         err_d     = 1'b1;
      end
   end
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         inh_q      <= '0;
         to_q       <= '0;
         sh_q       <= '0;
         bit_q      <= '0;
         clk_low_q  <= 1'b0;
         dat_low_q  <= 1'b0;
         err_q      <= 1'b0;
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         inh_q      <= inh_d;
         to_q       <= to_d;
         sh_q       <= sh_d;
         bit_q      <= bit_d;
         clk_low_q  <= clk_low_d;
         dat_low_q  <= dat_low_d;
         err_q      <= err_d;
         clk_sync_q <= {clk_sync_q[0], PS2_CLK};
         dat_sync_q <= {dat_sync_q[0], PS2_DAT};
         clk_prev_q <= clk_s;
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and random PS/2 host-to-device frames against a
// clocking device model; expected frames come from the byte and its ones count.
module tb_ps2_host_tx;
   localparam int INH = 1000;
   localparam int TO  = 3000;
   localparam int H   = 8;
   logic       clk = 1'b0, resetn = 1'b0, cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, tx_done, tx_error;
   logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0;
   wire        ps2_clk, ps2_dat;
   int checks = 0, errors = 0;
   int done_cnt = 0, err_cnt = 0, acc_cnt = 0, both_cnt = 0, cyc = 0;
   pullup (ps2_clk);
   pullup (ps2_dat);
   assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
   assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
   always #10 clk = ~clk;
   ps2_host_tx #(.CLK_INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .CLOCK_50(clk), .resetn(resetn), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .tx_done(tx_done), .tx_error(tx_error),
      .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat));
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_error) err_cnt <= err_cnt + 1;
      if (tx_done && tx_error) both_cnt <= both_cnt + 1;
      if (resetn && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
   end
   function automatic logic [9:0] frame_ref(input logic [7:0] d);
      return {1'b1, ($countones(d) % 2 == 0), d};
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] d);
      int k = 0;
      while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
      check("ready_before_send", cmd_ready, 1);
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask
   task automatic inhibit_phase(output int t0);
      int n = 0, bad = 0;
      while (ps2_clk === 1'b0 && n < INH + 100) begin
         if (ps2_dat !== 1'b1) bad++;
         n++;
         @(negedge clk);
      end
      check("inhibit_len", n, INH);
      check("inhibit_dat_released", bad, 0);
      check("start_bit", ps2_dat, 0);
      t0 = cyc;
   endtask
   task automatic dev_clock(output logic s);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      s = ps2_dat;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
   endtask
   task automatic dev_frame(input bit ack, output logic [9:0] bits);
      logic s;
      repeat (H) @(negedge clk);
      for (int i = 0; i < 10; i++) begin dev_clock(s); bits[i] = s; end
      if (ack) dev_dat_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clock(s);
      dev_dat_low = 1'b0;
   endtask
   task automatic wait_end(input int d0, input int e0);
      int k = 0;
      while (done_cnt == d0 && err_cnt == e0 && k < 200) begin @(negedge clk); k++; end
      repeat (4) @(negedge clk);
   endtask
   task automatic xfer(input logic [7:0] d, input bit ack, output logic [9:0] bits);
      int d0, e0, t0;
      d0 = done_cnt;
      e0 = err_cnt;
      send(d);
      inhibit_phase(t0);
      dev_frame(ack, bits);
      check("frame_bits", bits, frame_ref(d));
      wait_end(d0, e0);
      check("done_pulses", done_cnt - d0, ack ? 1 : 0);
      check("error_pulses", err_cnt - e0, ack ? 0 : 1);
      check("ready_after", cmd_ready, 1);
      check("lines_released", {ps2_clk, ps2_dat}, 2'b11);
   endtask
   initial begin
      logic [9:0] bits;
      logic s;
      int d0, e0, a0, t0, k;
      repeat (3) @(negedge clk);
      check("rst_ready", cmd_ready, 1);
      check("rst_done", tx_done, 0);
      check("rst_error", tx_error, 0);
      check("rst_lines", {ps2_clk, ps2_dat}, 2'b11);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      xfer(8'hED, 1'b1, bits);
      check("ed_bits", bits, 10'b11_1110_1101);
      xfer(8'h07, 1'b1, bits);
      check("parity_07", bits[8], 0);
      xfer(8'hFF, 1'b1, bits);
      check("parity_ff", bits[8], 1);
      xfer(8'h00, 1'b1, bits);
      check("parity_00", bits[8], 1);
      xfer(8'h3C, 1'b0, bits);
      // no device clocks at all: only the frame timeout ends this one
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hA5);
      inhibit_phase(t0);
      k = 0;
      while (!tx_error && k < TO + 100) begin @(negedge clk); k++; end
      check("timeout_cycles", cyc - t0, TO);
      repeat (3) @(negedge clk);
      check("timeout_errors", err_cnt - e0, 1);
      check("timeout_no_done", done_cnt - d0, 0);
      check("timeout_lines", {ps2_clk, ps2_dat}, 2'b11);
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hF0);
      inhibit_phase(t0);
      for (int i = 0; i < 4; i++) begin dev_clock(s); bits[i] = s; end
      check("partial_bits", bits[3:0], 4'h0);
      check("bit3_driven", ps2_dat, 0);
      #2 resetn = 1'b0;
      #1;
      check("midrst_lines", {ps2_clk, ps2_dat}, 2'b11);
      check("midrst_ready", cmd_ready, 1);
      check("midrst_pulses", {tx_done, tx_error}, 2'b00);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
      xfer(8'hF4, 1'b1, bits);
      a0 = acc_cnt;
      cmd_data  = 8'h5A;
      cmd_valid = 1'b1;
      @(negedge clk);
      inhibit_phase(t0);
      dev_frame(1'b1, bits);
      check("held_frame", bits, frame_ref(8'h5A));
      k = 0;
      while (!tx_done && k < 200) begin @(negedge clk); k++; end
      check("held_done_seen", tx_done, 1);
      check("held_one_accept", acc_cnt - a0, 1);
      @(negedge clk);
      @(negedge clk);
      check("held_second_accept", acc_cnt - a0, 2);
      check("held_busy_again", cmd_ready, 0);
      cmd_valid = 1'b0;
      d0 = done_cnt;
      e0 = err_cnt;
      inhibit_phase(t0);
      dev_frame(1'b1, bits);
      check("held_frame2", bits, frame_ref(8'h5A));
      wait_end(d0, e0);
      check("held_done2", done_cnt - d0, 1);
      check("held_total_accepts", acc_cnt - a0, 2);
      for (int i = 0; i < 3; i++) xfer(8'($urandom_range(0, 255)), 1'b1, bits);
      check("no_done_and_error", both_cnt, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
